// File: rtl/i2s_pkg.sv
// Shared definitions for the I2S transmit serializer.
//   DEFAULT_WIDTH    : default sample width (bits per slot)
//   FRAME_BITS       : default frame length in BCLK periods (two slots)
//   MAX_WIDTH        : widest sample the helpers below support
//   bit_cnt_t        : BCLK-period counter within a frame, sized for MAX_WIDTH
//   offset_to_signed : offset-binary to two's complement (flip the sample MSB)
package i2s_pkg;

    localparam int unsigned DEFAULT_WIDTH = 16;
    localparam int unsigned FRAME_BITS    = 2 * DEFAULT_WIDTH;
    localparam int unsigned MAX_WIDTH     = 32;

    typedef logic [$clog2(2 * MAX_WIDTH)-1:0] bit_cnt_t;

    // Operates on a MAX_WIDTH container; w is the live sample width.
    function automatic logic [MAX_WIDTH-1:0] offset_to_signed(input logic [MAX_WIDTH-1:0] s,
                                                              input int unsigned          w);
        return s ^ (MAX_WIDTH'(1) << (w - 1));
    endfunction

endpackage

// File: rtl/i2s_bclk_gen.sv
// Bit-clock divider for the I2S serializer.
//   clk    : system clock
//   rst_n  : asynchronous active-low reset
//   en_i   : enable; while low the divider and bclk are cleared on the next edge
//   bclk_o : registered bit clock, toggles every CLK_DIV enabled clk cycles
//   rise_o : combinational strobe, high in the cycle whose edge drives bclk 0->1
//   fall_o : combinational strobe, high in the cycle whose edge drives bclk 1->0
module i2s_bclk_gen #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    output logic bclk_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(CLK_DIV - 1);

    logic [CntW-1:0] cnt_d, cnt_q;
    logic            bclk_d, bclk_q;
    logic            terminal;

    assign terminal = (cnt_q == CntLast);

    always_comb begin
        cnt_d  = cnt_q;
        bclk_d = bclk_q;
        if (!en_i) begin
            cnt_d  = '0;
            bclk_d = 1'b0;
        end else if (terminal) begin
            cnt_d  = '0;
            bclk_d = ~bclk_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            bclk_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            bclk_q <= bclk_d;
        end
    end

    assign bclk_o = bclk_q;
    assign rise_o = en_i & terminal & ~bclk_q;
    assign fall_o = en_i & terminal & bclk_q;

endmodule

// File: rtl/i2s_tx_serializer.sv
// Philips I2S transmitter: accepts offset-binary samples, converts them to two's
// complement and sends each one on both the left and right slot, MSB first.
//   clk, rst_n      : system clock, asynchronous active-low reset
//   en_i            : stream enable; low clears BCLK/LRCK/SDATA and restarts the frame
//   sample_i        : offset-binary sample, taken when sample_valid_i & sample_ready_o
//   sample_valid_i  : sample_i is valid
//   sample_ready_o  : holding register empty
//   i2s_bclk_o      : bit clock
//   i2s_lrck_o      : word select, 0 = left, 1 = right (leads each slot by one BCLK)
//   i2s_sdata_o     : serial data, changes only on BCLK falling edges
//   frame_start_o   : one-clk pulse when a new frame word is loaded
//   underrun_o      : one-clk pulse when a frame loads with the holding register empty
module i2s_tx_serializer
    import i2s_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_WIDTH,
    parameter int unsigned CLK_DIV    = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en_i,
    input  logic [DATA_WIDTH-1:0] sample_i,
    input  logic                  sample_valid_i,
    output logic                  sample_ready_o,
    output logic                  i2s_bclk_o,
    output logic                  i2s_lrck_o,
    output logic                  i2s_sdata_o,
    output logic                  frame_start_o,
    output logic                  underrun_o
);

    localparam int unsigned FrameBits = 2 * DATA_WIDTH;
    localparam bit_cnt_t    LastBit   = bit_cnt_t'(FrameBits - 1);
    // LRCK switches one BCLK ahead of each slot MSB.
    localparam bit_cnt_t    LrckFirst = bit_cnt_t'(DATA_WIDTH - 1);
    localparam bit_cnt_t    LrckLast  = bit_cnt_t'(FrameBits - 2);

    logic bclk_fall;
    logic unused_bclk_rise;

    i2s_bclk_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_bclk_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (en_i),
        .bclk_o(i2s_bclk_o),
        .rise_o(unused_bclk_rise),
        .fall_o(bclk_fall)
    );

    logic [MAX_WIDTH-1:0]  sample_ext;
    logic [MAX_WIDTH-1:0]  unused_sample_ext;
    logic [DATA_WIDTH-1:0] sample_signed;

    assign sample_ext        = offset_to_signed(MAX_WIDTH'(sample_i), DATA_WIDTH);
    assign unused_sample_ext = sample_ext;
    assign sample_signed     = sample_ext[DATA_WIDTH-1:0];

    logic [DATA_WIDTH-1:0] hold_d, hold_q;
    logic                  hold_full_d, hold_full_q;
    logic [DATA_WIDTH-1:0] last_d, last_q;
    logic [FrameBits-1:0]  shreg_d, shreg_q;
    bit_cnt_t              bit_cnt_d, bit_cnt_q;
    logic                  lrck_d, lrck_q;
    logic                  sdata_d, sdata_q;
    logic                  frame_start_d, frame_start_q;
    logic                  underrun_d, underrun_q;
    logic [DATA_WIDTH-1:0] load_word;

    always_comb begin
        hold_d        = hold_q;
        hold_full_d   = hold_full_q;
        last_d        = last_q;
        shreg_d       = shreg_q;
        bit_cnt_d     = bit_cnt_q;
        lrck_d        = lrck_q;
        sdata_d       = sdata_q;
        frame_start_d = 1'b0;
        underrun_d    = 1'b0;
        load_word     = last_q;

        if (!en_i) begin
            bit_cnt_d = LastBit;
            lrck_d    = 1'b0;
            sdata_d   = 1'b0;
        end else if (bclk_fall) begin
            if (bit_cnt_q == LastBit) begin
                // Frame load uses the hold state from before this edge.
                bit_cnt_d     = '0;
                frame_start_d = 1'b1;
                if (hold_full_q) begin
                    load_word   = hold_q;
                    hold_full_d = 1'b0;
                    last_d      = hold_q;
                end else begin
                    underrun_d = 1'b1;
                end
                shreg_d = {load_word, load_word};
            end else begin
                bit_cnt_d = bit_cnt_q + 1'b1;
                shreg_d   = {shreg_q[FrameBits-2:0], 1'b0};
            end
            sdata_d = shreg_d[FrameBits-1];
            lrck_d  = (bit_cnt_d >= LrckFirst) && (bit_cnt_d <= LrckLast);
        end

        // Accept only when empty, so this never collides with the load clearing hold.
        if (sample_valid_i && !hold_full_q) begin
            hold_d      = sample_signed;
            hold_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q        <= '0;
            hold_full_q   <= 1'b0;
            last_q        <= '0;
            shreg_q       <= '0;
            bit_cnt_q     <= LastBit;
            lrck_q        <= 1'b0;
            sdata_q       <= 1'b0;
            frame_start_q <= 1'b0;
            underrun_q    <= 1'b0;
        end else begin
            hold_q        <= hold_d;
            hold_full_q   <= hold_full_d;
            last_q        <= last_d;
            shreg_q       <= shreg_d;
            bit_cnt_q     <= bit_cnt_d;
            lrck_q        <= lrck_d;
            sdata_q       <= sdata_d;
            frame_start_q <= frame_start_d;
            underrun_q    <= underrun_d;
        end
    end

    assign sample_ready_o = ~hold_full_q;
    assign i2s_lrck_o     = lrck_q;
    assign i2s_sdata_o    = sdata_q;
    assign frame_start_o  = frame_start_q;
    assign underrun_o     = underrun_q;

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Self-checking bench: two serializers (CLK_DIV=4 and CLK_DIV=1) share the
// stimulus; each is compared every cycle against a time-based reference model.
module tb_i2s_tx_serializer;

    localparam int W  = 16;
    localparam int FB = 2 * W;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [15:0] sample;
    logic        valid;

    logic a_ready, a_bclk, a_lrck, a_sdata, a_fs, a_ur;
    logic b_ready, b_bclk, b_lrck, b_sdata, b_fs, b_ur;

    always #5 clk = ~clk;

    i2s_tx_serializer #(.DATA_WIDTH(16), .CLK_DIV(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .en_i(en), .sample_i(sample), .sample_valid_i(valid),
        .sample_ready_o(a_ready), .i2s_bclk_o(a_bclk), .i2s_lrck_o(a_lrck),
        .i2s_sdata_o(a_sdata), .frame_start_o(a_fs), .underrun_o(a_ur)
    );

    i2s_tx_serializer #(.DATA_WIDTH(16), .CLK_DIV(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .en_i(en), .sample_i(sample), .sample_valid_i(valid),
        .sample_ready_o(b_ready), .i2s_bclk_o(b_bclk), .i2s_lrck_o(b_lrck),
        .i2s_sdata_o(b_sdata), .frame_start_o(b_fs), .underrun_o(b_ur)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: enabled-edge count since (re)enable gives every output.
    int          m_t[2];
    bit          m_hold_full[2];
    logic [15:0] m_hold[2];
    logic [15:0] m_last[2];
    logic [31:0] m_frame[2];
    bit          e_bclk[2], e_lrck[2], e_sdata[2], e_fs[2], e_ur[2];

    function automatic int clk_div(input int d);
        return (d == 0) ? 4 : 1;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_t[d] = 0; m_hold_full[d] = 0; m_hold[d] = '0; m_last[d] = '0; m_frame[d] = '0;
            e_bclk[d] = 0; e_lrck[d] = 0; e_sdata[d] = 0; e_fs[d] = 0; e_ur[d] = 0;
        end
    endtask

    // Predicts the state after the coming rising edge, from the inputs now applied.
    task automatic model_step();
        int          cdv, p, k;
        bit          acc;
        logic [15:0] s;
        for (int d = 0; d < 2; d++) begin
            cdv = clk_div(d);
            acc = valid && !m_hold_full[d];
            e_fs[d] = 0;
            e_ur[d] = 0;
            if (!en) begin
                m_t[d] = 0; e_bclk[d] = 0; e_lrck[d] = 0; e_sdata[d] = 0;
            end else begin
                m_t[d]++;
                e_bclk[d] = ((m_t[d] / cdv) % 2) == 1;
                if (m_t[d] % (2 * cdv) == 0) begin
                    p = m_t[d] / (2 * cdv) - 1;
                    k = p % FB;
                    if (k == 0) begin
                        if (m_hold_full[d]) begin
                            s = m_hold[d]; m_hold_full[d] = 0; m_last[d] = s;
                        end else begin
                            s = m_last[d]; e_ur[d] = 1;
                        end
                        m_frame[d] = {s, s};
                        e_fs[d] = 1;
                    end
                    e_lrck[d]  = (k >= W - 1) && (k <= 2 * W - 2);
                    e_sdata[d] = m_frame[d][FB-1-k];
                end
            end
            if (acc) begin
                m_hold[d] = sample - 16'h8000;
                m_hold_full[d] = 1;
            end
        end
    endtask

    task automatic check_all();
        check_eq("a_bclk",  32'(a_bclk),  32'(e_bclk[0]));
        check_eq("a_lrck",  32'(a_lrck),  32'(e_lrck[0]));
        check_eq("a_sdata", 32'(a_sdata), 32'(e_sdata[0]));
        check_eq("a_fs",    32'(a_fs),    32'(e_fs[0]));
        check_eq("a_ur",    32'(a_ur),    32'(e_ur[0]));
        check_eq("a_ready", 32'(a_ready), 32'(!m_hold_full[0]));
        check_eq("b_bclk",  32'(b_bclk),  32'(e_bclk[1]));
        check_eq("b_lrck",  32'(b_lrck),  32'(e_lrck[1]));
        check_eq("b_sdata", 32'(b_sdata), 32'(e_sdata[1]));
        check_eq("b_fs",    32'(b_fs),    32'(e_fs[1]));
        check_eq("b_ur",    32'(b_ur),    32'(e_ur[1]));
        check_eq("b_ready", 32'(b_ready), 32'(!m_hold_full[1]));
    endtask

    // Called at a falling edge with inputs already set.
    task automatic cycle();
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic wait_empty(input string tag);
        int n = 0;
        while ((m_hold_full[0] || m_hold_full[1]) && n < 400) begin
            cycle();
            n++;
        end
        check_eq(tag, 32'(m_hold_full[0] || m_hold_full[1]), 32'd0);
    endtask

    task automatic push_one(input logic [15:0] s, input string tag);
        wait_empty(tag);
        sample = s;
        valid  = 1'b1;
        cycle();
        valid  = 1'b0;
    endtask

    initial begin
        int n;
        bit hit;
        rst_n = 1'b0; en = 1'b0; valid = 1'b0; sample = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check_all();
        rst_n = 1'b1;

        // Idle, disabled
        repeat (100) cycle();

        // Midscale sample, first frame_start 8 clk after enable
        sample = 16'h7FFF; valid = 1'b1; en = 1'b1;
        cycle();
        valid = 1'b0;
        n = 1;
        while (!a_fs && n < 20) begin
            cycle();
            n++;
        end
        check_eq("first_fs_clk", 32'(n), 32'd8);
        repeat (600) cycle();

        // Extremes on consecutive frames
        push_one(16'hFFFF, "empty_before_ffff");
        push_one(16'h0000, "empty_before_0000");
        repeat (300) cycle();

        // Same-cycle accept on the load edge of dut_a with hold empty
        wait_empty("empty_before_same");
        n = 0;
        hit = 0;
        while (!hit && n < 600) begin
            if (en && !m_hold_full[0] && ((m_t[0] + 1) % 8 == 0) &&
                (((m_t[0] + 1) / 8 - 1) % FB == 0)) begin
                hit = 1;
            end else begin
                cycle();
                n++;
            end
        end
        check_eq("same_cycle_found", 32'(hit), 32'd1);
        sample = 16'h1234; valid = 1'b1;
        cycle();
        valid = 1'b0;
        repeat (300) cycle();

        // Mid-frame disable at bit 9 with a sample waiting in hold
        push_one(16'hA5C3, "empty_before_dis");
        n = 0;
        while (!((m_t[0] % 8 == 3) && ((m_t[0] / 8 - 1) % FB == 9) && m_t[0] >= 8) && n < 600) begin
            cycle();
            n++;
        end
        check_eq("bit9_found", 32'(n < 600), 32'd1);
        en = 1'b0;
        repeat (6) cycle();
        en = 1'b1;
        repeat (400) cycle();

        // Randomized traffic with occasional disables
        for (int i = 0; i < 3000; i++) begin
            valid  = ($urandom_range(0, 3) == 0);
            sample = 16'($urandom);
            if ($urandom_range(0, 399) == 0) en = ~en;
            cycle();
        end
        valid = 1'b0;
        en = 1'b1;
        repeat (100) cycle();

        // Asynchronous reset mid-frame, then post-reset underrun sends silence
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        check_all();
        rst_n = 1'b1;
        repeat (300) cycle();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
